shift_add_mac: RTL
==================

Name: shift_add_mac

Overview:
- Sequential unsigned multiply-accumulate stage.
- Accepts one operand pair per transaction and multiplies by shift-and-add, one multiplier bit per clock.
- Adds the product into a running accumulator, which drives the downstream storage latch bank.
- Fixed latency and a valid/ready input handshake let the surrounding MAC control sequence dot-product terms.

Parameters:
WIDTH, 8, operand width in bits (a and b)
ACC_WIDTH, 20, accumulator width in bits; must be >= 2*WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair a/b presented
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
acc_clear  input  1  synchronous accumulator clear
busy  output  1  transaction in progress (state != IDLE)
out_valid  output  1  one-cycle pulse: acc_out holds newly accumulated value
acc_out  output  ACC_WIDTH  accumulator value
overflow  output  1  sticky: accumulator wrapped since last clear/reset

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset (rst high at a clk edge): state=IDLE, acc_out=0, overflow=0, out_valid=0, busy=0, in_ready=1. Internal product/shift registers are zeroed. rst overrides all other inputs, including mid-transaction; no out_valid is produced for an aborted operation.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch a and b, zero the product, load counter=WIDTH, go to MUL.
  - MUL: each cycle, if the current b LSB is 1, product += a shifted left by the step index (2*WIDTH-bit add, no loss). Shift b right, decrement the counter. After exactly WIDTH cycles go to ACC. Always WIDTH cycles; no early exit on zero operands.
  - ACC: acc_out <= (acc_out + product) mod 2^ACC_WIDTH. Carry out of the add sets overflow (sticky). out_valid=1 in the following cycle. Return to IDLE.
- Timing: accept edge at T → out_valid high for the single cycle after edge T+WIDTH+1, with acc_out already updated. Next accept is possible on the edge that ends that cycle (one transaction per WIDTH+2 cycles).
- Handshake: the transfer happens only on in_valid & in_ready at an edge. in_valid while busy is ignored, not queued. a/b may change freely after the accept edge.
- busy = (state != IDLE); in_ready = !busy.
- acc_clear:
  - IDLE or MUL: acc_out<=0 and overflow<=0 at that edge; an in-flight multiply continues unaffected.
  - Same edge as the ACC update: clear-then-add, so acc_out<=product and overflow<=0.
  - Same edge as an accept in IDLE: clear applies and the transaction is accepted.
  - Does not generate out_valid.
- acc_out is stable outside the ACC update and clear edges. overflow is cleared only by rst or acc_clear.

Test Plan:
1. rst 2 cycles, then a=3,b=5,in_valid one cycle → in_ready/busy toggle at the accept edge; out_valid pulses exactly WIDTH+1 (=9) edges later with acc_out=15, overflow=0.
2. Back-to-back a=255,b=255 twice, in_valid asserted on the first in_ready → acc_out=65025 after the first, 130050 after the second; second accept occurs the cycle out_valid is high.
3. Seventeen 255*255 transactions, ACC_WIDTH=20 → after the 16th acc_out=1040400, overflow=0; after the 17th acc_out=56849, overflow=1. acc_clear then gives acc_out=0, overflow=0.
4. With acc_out=100, accept a=2,b=3, pulse acc_clear mid-MUL → acc_out=0 immediately, final acc_out=6. Repeat with acc_clear on the ACC edge → acc_out=6.
5. Accept a=7,b=9, then drive a=0,b=0 and hold in_valid=1 during MUL → in_ready=0 throughout, no second accept before IDLE, result acc_out=63.
6. Accept a=10,b=10, assert rst at MUL cycle 4 → next edge all outputs at reset values, state IDLE, no out_valid ever; fresh a=1,b=1 then yields acc_out=1.

Source files
------------

// File: rtl/shift_add_mac.sv
// Sequential unsigned multiply-accumulate: shift-and-add multiply, one multiplier
// bit per clock, then the product is added into a sticky-overflow accumulator.
module shift_add_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_clear,
  output logic                 busy,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;
  logic [ACC_WIDTH:0]   sum;

  // One extra bit captures the carry out of the accumulator add
  assign sum      = {1'b0, acc_out} + (ACC_WIDTH+1)'(product);
  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      product   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_clear) begin
            acc_out  <= '0;
            overflow <= 1'b0;
          end
          if (in_valid) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            product <= '0;
            count   <= CW'(WIDTH);
            state   <= MUL;
          end
        end
        MUL: begin
          if (acc_clear) begin
            acc_out  <= '0;
            overflow <= 1'b0;
          end
          // The multiplicand register carries the step-index shift
          if (mplier[0]) begin
            product <= product + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= ACC;
          end
        end
        ACC: begin
          // A clear on this edge is applied before the add
          if (acc_clear) begin
            acc_out  <= ACC_WIDTH'(product);
            overflow <= 1'b0;
          end else begin
            acc_out  <= sum[ACC_WIDTH-1:0];
            overflow <= overflow | sum[ACC_WIDTH];
          end
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
